// File: rtl/chip_spreading.sv
// -----------------------------------------------------------------------------
// chip_spreading
//
// Turns the serial PPDU bit stream from the framing/encoding chain into
// IEEE 802.15.4 (2.4 GHz O-QPSK) DSSS chips. Bits are packed LSB first into
// 4-bit symbols. Each symbol is queued in a small FIFO. A chip engine driven by
// the modulator's chip-rate strobe then expands each symbol into its 32-chip
// PN sequence, starting with chip c0 (the MSB).
//
// Parameters:
//   FIFO_DEPTH      number of queued symbols (a power of 2, >= 2)
//
// Ports:
//   clk             system clock, rising edge
//   reset_n         asynchronous active-low reset
//   bit_in          serial data bit (from framing_encoding_out)
//   bit_in_valid    qualifies bit_in, at most one bit per cycle
//   chip_tick       chip-rate strobe, one chip per high cycle
//   chip_out        current chip (0 whenever chip_out_valid is 0)
//   chip_out_valid  one-cycle pulse qualifying chip_out
//   overflow        a completed symbol was dropped because the FIFO was full
//
// Build option:
//   CHIP_SPREADING_STICKY_OVF_EN  defined  : overflow is set by the first drop
//                                            and held until reset_n
//                                 undefined: overflow is a one-cycle pulse
//                                            after each dropped symbol
// -----------------------------------------------------------------------------
module chip_spreading #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic bit_in,
  input  logic bit_in_valid,
  input  logic chip_tick,
  output logic chip_out,
  output logic chip_out_valid,
  output logic overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Chip engine states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // Symbols 8..15 invert the odd chips of symbols 0..7
  localparam logic [31:0] ODD_CHIP_MASK = 32'h5555_5555;

  // ---------------------------------------------------------------------------
  // Symbol-to-chip ROM. Symbols 1..7 are symbol 0 rotated right by four chips
  // per step. The eight base sequences are listed explicitly so the table
  // can be checked against the standard directly.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] f_spread(input logic [3:0] i_sym);
    logic [31:0] v_base;
    case (i_sym[2:0])
      3'd0:    v_base = 32'hD9C3_522E;
      3'd1:    v_base = 32'hED9C_3522;
      3'd2:    v_base = 32'h2ED9_C352;
      3'd3:    v_base = 32'h22ED_9C35;
      3'd4:    v_base = 32'h522E_D9C3;
      3'd5:    v_base = 32'h3522_ED9C;
      3'd6:    v_base = 32'hC352_2ED9;
      default: v_base = 32'h9C35_22ED;
    endcase
    return i_sym[3] ? (v_base ^ ODD_CHIP_MASK) : v_base;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0]      r_bit_cnt;       // next nibble position to fill
  logic [2:0]      r_nibble;        // bits b0..b2 of the nibble being built
  logic [3:0]      r_mem [FIFO_DEPTH];
  logic [AW:0]     r_wr_ptr;        // extra MSB separates full from empty
  logic [AW:0]     r_rd_ptr;
  logic [0:0]      r_state;
  logic [4:0]      r_chip_cnt;      // index of the next chip to emit in SEND
  logic [31:0]     r_shift;         // next chip to send sits in bit 31
  logic            r_chip_out;
  logic            r_chip_valid;
  logic            r_overflow;

  // ---------------------------------------------------------------------------
  // Wires
  // ---------------------------------------------------------------------------
  logic            w_push;          // a nibble completes on this edge
  logic [3:0]      w_push_sym;
  logic            w_empty;
  logic            w_full;
  logic            w_sym_end;       // the chip going out now is c31
  logic            w_pop;
  logic            w_push_ok;
  logic            w_drop;
  logic [3:0]      w_head_sym;
  logic [31:0]     w_head_chips;

  assign w_push     = bit_in_valid && (r_bit_cnt == 2'd3);
  assign w_push_sym = {bit_in, r_nibble};

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_sym_end = (r_chip_cnt == 5'd31);

  // Emptiness comes from registered pointers, so a symbol pushed on this edge
  // cannot be popped on the same edge. The engine simply waits one tick.
  assign w_pop = chip_tick && !w_empty &&
                 ((r_state == ST_IDLE) || ((r_state == ST_SEND) && w_sym_end));

  // A pop on the same edge frees the slot, so a push into a full FIFO still
  // succeeds in that case.
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  assign w_head_sym   = r_mem[r_rd_ptr[AW-1:0]];
  assign w_head_chips = f_spread(w_head_sym);

  // ---------------------------------------------------------------------------
  // Bit assembly
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so that every block
  // samples the values from before the edge, whatever the evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt <= 2'd0;
      r_nibble  <= 3'd0;
    end else if (bit_in_valid) begin
      r_bit_cnt <= r_bit_cnt + 2'd1;
      case (r_bit_cnt)
        2'd0:    r_nibble[0] <= bit_in;
        2'd1:    r_nibble[1] <= bit_in;
        2'd2:    r_nibble[2] <= bit_in;
        default: r_nibble    <= r_nibble;  // bit 3 goes straight to the FIFO
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Symbol FIFO
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset. Emptiness is defined by the pointers
  // alone, so stale entries are never read. Leaving the array out of reset
  // lets it map onto plain flops or distributed RAM.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_push_sym;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Chip engine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_chip_cnt   <= 5'd0;
      r_shift      <= 32'd0;
      r_chip_out   <= 1'b0;
      r_chip_valid <= 1'b0;
    end else begin
      // The outputs are a one-cycle pulse per tick. With no tick they return
      // to 0 while the engine state holds.
      r_chip_out   <= 1'b0;
      r_chip_valid <= 1'b0;
      if (chip_tick) begin
        case (r_state)
          ST_IDLE: begin
            if (!w_empty) begin
              // c0 goes out on the popping tick. The rest waits in the shifter.
              r_chip_out   <= w_head_chips[31];
              r_chip_valid <= 1'b1;
              r_shift      <= {w_head_chips[30:0], 1'b0};
              r_chip_cnt   <= 5'd1;
              r_state      <= ST_SEND;
            end
          end
          default: begin
            r_chip_out   <= r_shift[31];
            r_chip_valid <= 1'b1;
            r_chip_cnt   <= r_chip_cnt + 5'd1;  // wraps to 0 after c31
            if (w_sym_end) begin
              if (!w_empty) begin
                // Reload the whole symbol. Its c0 goes out on the next tick,
                // directly after this c31.
                r_shift <= w_head_chips;
              end else begin
                r_shift <= 32'd0;
                r_state <= ST_IDLE;
              end
            end else begin
              r_shift <= {r_shift[30:0], 1'b0};
            end
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Overflow indication
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else begin
`ifdef CHIP_SPREADING_STICKY_OVF_EN
      r_overflow <= r_overflow || w_drop;
`else
      r_overflow <= w_drop;
`endif
    end
  end

  assign chip_out       = r_chip_out;
  assign chip_out_valid = r_chip_valid;
  assign overflow       = r_overflow;

endmodule

// File: tb/tb_chip_spreading.sv
// -----------------------------------------------------------------------------
// tb_chip_spreading
//
// Self-checking bench for chip_spreading. It sends bytes LSB first and
// collects the valid chips at the falling edge. It then compares each 32-chip
// word with the hand-computed PN table and checks timing, overflow and
// reset behaviour.
// -----------------------------------------------------------------------------
module tb_chip_spreading;

  localparam int FIFO_DEPTH = 4;

  logic clk            = 1'b0;
  logic reset_n        = 1'b0;
  logic bit_in         = 1'b0;
  logic bit_in_valid   = 1'b0;
  logic chip_tick      = 1'b0;
  logic chip_out;
  logic chip_out_valid;
  logic overflow;

  chip_spreading #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bit_in         (bit_in),
    .bit_in_valid   (bit_in_valid),
    .chip_tick      (chip_tick),
    .chip_out       (chip_out),
    .chip_out_valid (chip_out_valid),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Cycle counter, stepped at each rising edge
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Chip-rate strobe: 0 = off, N = high once every N cycles
  int tick_period = 0;
  int tick_phase  = 0;
  initial forever begin
    @(posedge clk);
    #1;
    tick_phase++;
    if (tick_period > 0) chip_tick = ((tick_phase % tick_period) == 0);
    else                 chip_tick = 1'b0;
  end

  // Output monitor, sampled on the falling edge
  bit   chips[$];
  int   first_valid = -1;
  int   last_valid  = -1;
  int   n_orphan    = 0;   // valid without a tick on the previous edge
  int   n_dirty     = 0;   // chip_out high while chip_out_valid low
  int   n_ovf       = 0;   // cycles with overflow high
  logic tick_prev   = 1'b0;
  initial forever begin
    @(negedge clk);
    if (chip_out_valid === 1'b1) begin
      if (chips.size() == 0) first_valid = cyc;
      last_valid = cyc;
      chips.push_back(chip_out);
      if (tick_prev !== 1'b1) n_orphan++;
    end else if (chip_out !== 1'b0) begin
      n_dirty++;
    end
    if (overflow === 1'b1) n_ovf++;
    tick_prev = chip_tick;
  end

  task automatic clear_mon();
    chips.delete();
    first_valid = -1;
    last_valid  = -1;
    n_orphan    = 0;
    n_dirty     = 0;
    n_ovf       = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Send one nibble LSB first. t4 is the cycle index of the edge that sampled
  // the fourth bit.
  task automatic send_nibble(input logic [3:0] nib, input bit gaps, output int t4);
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        bit_in_valid = 1'b0;
        step($urandom_range(0, 3));
      end
      bit_in       = nib[i];
      bit_in_valid = 1'b1;
      step(1);
    end
    bit_in_valid = 1'b0;
    bit_in       = 1'b0;
    t4 = cyc;
  endtask

  task automatic wait_chips(input int n, input int budget);
    int k;
    k = 0;
    while (chips.size() < n && k < budget) begin
      step(1);
      k++;
    end
  endtask

  function automatic logic [31:0] get_word(input int w);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (w * 32 + i < chips.size()) r[31 - i] = chips[w * 32 + i];
    end
    return r;
  endfunction

  typedef struct {
    logic [7:0]  data;
    bit          gaps;
    int          period;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] sym_tab[4];

  initial begin : main
    int t4;
    int t_dummy;

    // Watchdog
    fork
      begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    vecs[0] = '{data: 8'h00, gaps: 1'b0, period: 1, exp0: 32'hD9C3522E, exp1: 32'hD9C3522E};
    vecs[1] = '{data: 8'hA7, gaps: 1'b0, period: 1, exp0: 32'h9C3522ED, exp1: 32'h7B8C9607};
    vecs[2] = '{data: 8'h18, gaps: 1'b1, period: 1, exp0: 32'h8C96077B, exp1: 32'hED9C3522};
    vecs[3] = '{data: 8'h3C, gaps: 1'b0, period: 3, exp0: 32'h077B8C96, exp1: 32'h22ED9C35};
    vecs[4] = '{data: 8'hF5, gaps: 1'b1, period: 1, exp0: 32'h3522ED9C, exp1: 32'hC96077B8};

    sym_tab[0] = 32'hD9C3522E;
    sym_tab[1] = 32'hED9C3522;
    sym_tab[2] = 32'h2ED9C352;
    sym_tab[3] = 32'h22ED9C35;

    // Reset state
    step(3);
    check("reset chip_out", {31'd0, chip_out}, 32'd0);
    check("reset chip_out_valid", {31'd0, chip_out_valid}, 32'd0);
    check("reset overflow", {31'd0, overflow}, 32'd0);
    reset_n = 1'b1;
    step(2);

    // Table-driven byte vectors
    for (int v = 0; v < 5; v++) begin
      tick_period = vecs[v].period;
      step(3);
      clear_mon();
      send_nibble(vecs[v].data[3:0], vecs[v].gaps, t4);
      send_nibble(vecs[v].data[7:4], vecs[v].gaps, t_dummy);
      wait_chips(64, 64 * vecs[v].period + 200);
      step(2 * vecs[v].period + 40);
      check($sformatf("vec%0d chip count", v), chips.size(), 64);
      check($sformatf("vec%0d symbol0 chips", v), get_word(0), vecs[v].exp0);
      check($sformatf("vec%0d symbol1 chips", v), get_word(1), vecs[v].exp1);
      check($sformatf("vec%0d chip_out low when idle", v), n_dirty, 0);
      if (vecs[v].period == 1) begin
        check($sformatf("vec%0d first chip latency", v), first_valid, t4 + 1);
        check($sformatf("vec%0d back-to-back span", v), last_valid - first_valid + 1, 64);
      end else begin
        check($sformatf("vec%0d valid only after tick", v), n_orphan, 0);
      end
    end

    // Overflow: 10 symbols with no ticks into a 4-deep FIFO
    tick_period = 0;
    step(3);
    clear_mon();
    for (int s = 0; s < 10; s++) begin
      send_nibble(s[3:0], 1'b0, t_dummy);
      if (s == 3) check("overflow quiet after 4 symbols", n_ovf, 0);
      if (s == 4) check("overflow on 5th symbol", {31'd0, overflow}, 32'd1);
    end
    step(2);
`ifdef CHIP_SPREADING_STICKY_OVF_EN
    check("sticky overflow held", {31'd0, overflow}, 32'd1);
`else
    check("overflow pulse count", n_ovf, 6);
    check("overflow pulse ended", {31'd0, overflow}, 32'd0);
`endif
    check("no chips while ticks off", chips.size(), 0);

    clear_mon();
    tick_period = 1;
    wait_chips(128, 400);
    step(60);
    check("drained chip count", chips.size(), 128);
    for (int w = 0; w < 4; w++) begin
      check($sformatf("drained symbol%0d chips", w), get_word(w), sym_tab[w]);
    end
    check("drain back-to-back span", last_valid - first_valid + 1, 128);
`ifdef CHIP_SPREADING_STICKY_OVF_EN
    check("sticky overflow after drain", {31'd0, overflow}, 32'd1);
`endif

    // Reset mid-symbol with two symbols still queued
    clear_mon();
    send_nibble(4'd5, 1'b0, t_dummy);
    send_nibble(4'd6, 1'b0, t_dummy);
    send_nibble(4'd7, 1'b0, t_dummy);
    wait_chips(10, 100);
    check("chips reached 10 before reset", chips.size(), 10);
    check("valid high before reset", {31'd0, chip_out_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset chip_out_valid", {31'd0, chip_out_valid}, 32'd0);
    check("async reset chip_out", {31'd0, chip_out}, 32'd0);
    check("async reset overflow", {31'd0, overflow}, 32'd0);
    step(2);
    reset_n = 1'b1;
    clear_mon();
    step(110);
    check("no chips after reset", chips.size(), 0);
    check("chip_out low after reset", n_dirty, 0);

    // The design still works after the reset
    clear_mon();
    send_nibble(4'd2, 1'b0, t4);
    wait_chips(32, 100);
    step(40);
    check("post-reset chip count", chips.size(), 32);
    check("post-reset symbol2 chips", get_word(0), 32'h2ED9C352);
    check("post-reset latency", first_valid, t4 + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
